// File: rtl/snoop_req_queue.sv
// Snoop request queue: buffers ACE AC snoops ahead of the D-cache snoop controller.
// Define SNOOP_REQ_QUEUE_BYPASS_EN to allow same-cycle bypass when the queue is empty.
module snoop_req_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 1,
    parameter int unsigned LINE_OFFSET     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ac_valid_i,
    output logic                    ac_ready_o,
    input  logic [63:0]             ac_addr_i,
    input  logic [3:0]              ac_snoop_i,
    input  logic [2:0]              ac_prot_i,
    output logic                    ac_valid_o,
    input  logic                    ac_ready_i,
    output logic [63:0]             ac_addr_o,
    output logic [3:0]              ac_snoop_o,
    output logic [2:0]              ac_prot_o,
    input  logic                    cr_done_i,
    input  logic                    flushing_i,
    input  logic                    amo_valid_i,
    input  logic [63:0]             amo_addr_i,
    output logic [$clog2(DEPTH):0]  fill_o,
    output logic                    busy_o,
    output logic                    stall_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PtrW:0]   FullFill = DEPTH[PtrW:0];
    localparam logic [CntW-1:0] MaxCnt   = MAX_OUTSTANDING[CntW-1:0];

    typedef struct packed {
        logic [63:0] addr;
        logic [3:0]  snoop;
        logic [2:0]  prot;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StHeadWait, StPresent} state_e;

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   fill_q, fill_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    state_e          state_q, state_d;

    entry_t head, in_entry, out_entry;
    logic   at_max, head_blocked;
    logic   valid, stall, hs, push, pop;
    logic   bypass_take;

    // Byte-offset bits of the AMO address never take part in the line compare.
    logic unused_amo_offset;
    assign unused_amo_offset = ^amo_addr_i[LINE_OFFSET-1:0];

    assign in_entry = '{addr: ac_addr_i, snoop: ac_snoop_i, prot: ac_prot_i};
    assign head     = mem_q[rd_ptr_q];
    assign at_max   = (cnt_q == MaxCnt);

    assign head_blocked = flushing_i | at_max |
        (amo_valid_i & (amo_addr_i[63:LINE_OFFSET] == head.addr[63:LINE_OFFSET]));

`ifdef SNOOP_REQ_QUEUE_BYPASS_EN
    logic in_blocked;
    assign in_blocked = flushing_i | at_max |
        (amo_valid_i & (amo_addr_i[63:LINE_OFFSET] == ac_addr_i[63:LINE_OFFSET]));
`endif

    // Ready depends on registered occupancy only, never on ac_valid_i.
    assign ac_ready_o = (fill_q != FullFill);

    always_comb begin
        state_d     = state_q;
        valid       = 1'b0;
        stall       = 1'b0;
        out_entry   = head;
        bypass_take = 1'b0;

        unique case (state_q)
            StIdle: begin
`ifdef SNOOP_REQ_QUEUE_BYPASS_EN
                if (ac_valid_i && !in_blocked && (fill_q == '0)) begin
                    valid       = 1'b1;
                    out_entry   = in_entry;
                    bypass_take = ac_ready_i;
                end
`endif
            end
            StHeadWait: begin
                if (head_blocked) begin
                    stall = 1'b1;
                end else begin
                    valid = 1'b1;
                end
            end
            StPresent: valid = 1'b1;
            default: state_d = StIdle;
        endcase

        hs   = valid & ac_ready_i;
        pop  = hs & ~bypass_take;
        push = ac_valid_i & ac_ready_o & ~bypass_take;

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        fill_d   = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + (PtrW + 1)'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - (PtrW + 1)'(1);
        end

        if (state_q == StIdle) begin
            // A valid offer from IDLE can only be a bypass that was not taken.
            if (push) begin
                state_d = valid ? StPresent : StHeadWait;
            end
        end else if (pop) begin
            state_d = (fill_d != '0) ? StHeadWait : StIdle;
        end else if (valid) begin
            state_d = StPresent;
        end

        cnt_d = cnt_q;
        if (hs && !cr_done_i) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!hs && cr_done_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= in_entry;
            end
        end
    end

    assign ac_valid_o = valid;
    assign ac_addr_o  = out_entry.addr;
    assign ac_snoop_o = out_entry.snoop;
    assign ac_prot_o  = out_entry.prot;
    assign fill_o     = fill_q;
    assign busy_o     = (fill_q != '0) | (cnt_q != '0);
    assign stall_o    = stall;

`ifndef SYNTHESIS
    // A CR completion with nothing outstanding indicates an upstream protocol error.
    cr_done_without_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) cr_done_i |-> ((cnt_q != '0) || hs));
`endif

endmodule

// File: tb/tb_snoop_req_queue.sv
// Directed self-checking bench for snoop_req_queue with default parameters
// (DEPTH=4, MAX_OUTSTANDING=1, LINE_OFFSET=4).
module tb_snoop_req_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ac_valid_i = 1'b0;
    logic        ac_ready_o;
    logic [63:0] ac_addr_i = '0;
    logic [3:0]  ac_snoop_i = '0;
    logic [2:0]  ac_prot_i = '0;
    logic        ac_valid_o;
    logic        ac_ready_i = 1'b0;
    logic [63:0] ac_addr_o;
    logic [3:0]  ac_snoop_o;
    logic [2:0]  ac_prot_o;
    logic        cr_done_i = 1'b0;
    logic        flushing_i = 1'b0;
    logic        amo_valid_i = 1'b0;
    logic [63:0] amo_addr_i = '0;
    logic [2:0]  fill_o;
    logic        busy_o;
    logic        stall_o;

    int n_checks = 0;
    int n_fail   = 0;

    snoop_req_queue dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .ac_valid_i  (ac_valid_i),
        .ac_ready_o  (ac_ready_o),
        .ac_addr_i   (ac_addr_i),
        .ac_snoop_i  (ac_snoop_i),
        .ac_prot_i   (ac_prot_i),
        .ac_valid_o  (ac_valid_o),
        .ac_ready_i  (ac_ready_i),
        .ac_addr_o   (ac_addr_o),
        .ac_snoop_o  (ac_snoop_o),
        .ac_prot_o   (ac_prot_o),
        .cr_done_i   (cr_done_i),
        .flushing_i  (flushing_i),
        .amo_valid_i (amo_valid_i),
        .amo_addr_i  (amo_addr_i),
        .fill_o      (fill_o),
        .busy_o      (busy_o),
        .stall_o     (stall_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_push(input logic [63:0] addr, input logic [3:0] snoop,
                              input logic [2:0] prot);
        ac_valid_i = 1'b1;
        ac_addr_i  = addr;
        ac_snoop_i = snoop;
        ac_prot_i  = prot;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " ready"}, 64'(ac_ready_o), 64'd1);
        check_eq({tag, " valid"}, 64'(ac_valid_o), 64'd0);
        check_eq({tag, " addr"},  ac_addr_o, 64'd0);
        check_eq({tag, " snoop"}, 64'(ac_snoop_o), 64'd0);
        check_eq({tag, " prot"},  64'(ac_prot_o), 64'd0);
        check_eq({tag, " fill"},  64'(fill_o), 64'd0);
        check_eq({tag, " busy"},  64'(busy_o), 64'd0);
        check_eq({tag, " stall"}, 64'(stall_o), 64'd0);
    endtask

    // Head is held by the outstanding limit; a CR pulse frees it for the next cycle.
    task automatic drain_one(input logic [63:0] exp_addr);
        cr_done_i = 1'b1;
        #1;
        check_eq("drain held", 64'(ac_valid_o), 64'd0);
        step();
        cr_done_i = 1'b0;
        #1;
        check_eq("drain valid", 64'(ac_valid_o), 64'd1);
        check_eq("drain addr", ac_addr_o, exp_addr);
        step();
    endtask

    task automatic retire();
        cr_done_i = 1'b1;
        step();
        cr_done_i = 1'b0;
        #1;
        check_eq("retire busy", 64'(busy_o), 64'd0);
    endtask

    logic [63:0] a_addr [5];

    initial begin
        for (int i = 0; i < 5; i++) a_addr[i] = 64'h100 + 64'(i) * 64'h40;

        // Reset state
        #2;
        check_reset_outputs("reset");
        step();
        rst_ni = 1'b1;

        // Single ReadShared
        drive_push(64'h8000_0040, 4'b0001, 3'b010);
        ac_ready_i = 1'b1;
        #1;
        check_eq("t1 ready", 64'(ac_ready_o), 64'd1);
        check_eq("t1 no bypass", 64'(ac_valid_o), 64'd0);
        step();
        ac_valid_i = 1'b0;
        #1;
        check_eq("t1 valid", 64'(ac_valid_o), 64'd1);
        check_eq("t1 addr", ac_addr_o, 64'h8000_0040);
        check_eq("t1 snoop", 64'(ac_snoop_o), 64'h1);
        check_eq("t1 prot", 64'(ac_prot_o), 64'h2);
        check_eq("t1 fill", 64'(fill_o), 64'd1);
        step();
        #1;
        check_eq("t1 valid drop", 64'(ac_valid_o), 64'd0);
        check_eq("t1 busy out", 64'(busy_o), 64'd1);
        step();
        step();
        cr_done_i = 1'b1;
        #1;
        check_eq("t1 busy at cr", 64'(busy_o), 64'd1);
        step();
        cr_done_i = 1'b0;
        #1;
        check_eq("t1 busy clear", 64'(busy_o), 64'd0);

        // Five back-to-back pushes into a depth-4 queue
        ac_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_push(a_addr[i], 4'b0111, 3'b000);
            #1;
            check_eq("t2 ready", 64'(ac_ready_o), 64'd1);
            if (i == 1) check_eq("t2 head", ac_addr_o, a_addr[0]);
            step();
        end
        drive_push(a_addr[4], 4'b0111, 3'b000);
        #1;
        check_eq("t2 full fill", 64'(fill_o), 64'd4);
        check_eq("t2 full ready", 64'(ac_ready_o), 64'd0);
        step();
        ac_ready_i = 1'b1;
        #1;
        check_eq("t2 pop ready", 64'(ac_ready_o), 64'd0);
        check_eq("t2 pop valid", 64'(ac_valid_o), 64'd1);
        check_eq("t2 pop addr", ac_addr_o, a_addr[0]);
        step();
        #1;
        check_eq("t2 after pop ready", 64'(ac_ready_o), 64'd1);
        check_eq("t2 after pop fill", 64'(fill_o), 64'd3);
        check_eq("t2 max stall", 64'(stall_o), 64'd1);
        step();
        ac_valid_i = 1'b0;
        #1;
        check_eq("t2 refill", 64'(fill_o), 64'd4);
        for (int i = 1; i < 5; i++) drain_one(a_addr[i]);
        retire();

        // Flush holds the head
        flushing_i = 1'b1;
        ac_ready_i = 1'b1;
        drive_push(64'h3000, 4'b1001, 3'b001);
        #1;
        check_eq("t3 idle stall", 64'(stall_o), 64'd0);
        step();
        drive_push(64'h3040, 4'b1001, 3'b001);
        for (int i = 1; i < 10; i++) begin
            #1;
            check_eq("t3 flush valid", 64'(ac_valid_o), 64'd0);
            check_eq("t3 flush stall", 64'(stall_o), 64'd1);
            step();
            ac_valid_i = 1'b0;
        end
        flushing_i = 1'b0;
        #1;
        check_eq("t3 release valid", 64'(ac_valid_o), 64'd1);
        check_eq("t3 release addr", ac_addr_o, 64'h3000);
        step();
        drain_one(64'h3040);
        retire();

        // AMO line conflict
        amo_valid_i = 1'b1;
        amo_addr_i  = 64'h1008;
        drive_push(64'h1000, 4'b0001, 3'b000);
        step();
        ac_valid_i = 1'b0;
        #1;
        check_eq("t4 amo block", 64'(ac_valid_o), 64'd0);
        check_eq("t4 amo stall", 64'(stall_o), 64'd1);
        amo_valid_i = 1'b0;
        #1;
        check_eq("t4 amo clear", 64'(ac_valid_o), 64'd1);
        check_eq("t4 amo clear addr", ac_addr_o, 64'h1000);
        step();
        retire();
        amo_valid_i = 1'b1;
        drive_push(64'h1010, 4'b0001, 3'b000);
        step();
        ac_valid_i = 1'b0;
        #1;
        check_eq("t4 other line", 64'(ac_valid_o), 64'd1);
        check_eq("t4 other stall", 64'(stall_o), 64'd0);
        step();
        retire();
        amo_valid_i = 1'b0;
        ac_ready_i  = 1'b0;
        drive_push(64'h2000, 4'b0001, 3'b000);
        step();
        ac_valid_i = 1'b0;
        step();
        amo_valid_i = 1'b1;
        amo_addr_i  = 64'h2004;
        flushing_i  = 1'b1;
        #1;
        check_eq("t4 present valid", 64'(ac_valid_o), 64'd1);
        check_eq("t4 present addr", ac_addr_o, 64'h2000);
        check_eq("t4 present stall", 64'(stall_o), 64'd0);
        step();
        ac_ready_i = 1'b1;
        #1;
        check_eq("t4 present hold", 64'(ac_valid_o), 64'd1);
        step();
        amo_valid_i = 1'b0;
        flushing_i  = 1'b0;
        retire();

        // Outstanding limit and simultaneous handshake / CR completion
        drive_push(64'h4000, 4'b0001, 3'b000);
        step();
        drive_push(64'h4040, 4'b0001, 3'b000);
        step();
        ac_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq("t5 held", 64'(ac_valid_o), 64'd0);
            check_eq("t5 held stall", 64'(stall_o), 64'd1);
            step();
        end
        cr_done_i = 1'b1;
        #1;
        check_eq("t5 cr cycle", 64'(ac_valid_o), 64'd0);
        step();
        #1;
        check_eq("t5 issue", 64'(ac_valid_o), 64'd1);
        check_eq("t5 issue addr", ac_addr_o, 64'h4040);
        step();
        cr_done_i = 1'b0;
        #1;
        check_eq("t5 net unchanged", 64'(busy_o), 64'd0);

        // Reset with three queued and one outstanding
        for (int i = 0; i < 4; i++) begin
            drive_push(64'h5000 + 64'(i) * 64'h40, 4'b0001, 3'b000);
            step();
        end
        ac_valid_i = 1'b0;
        #1;
        check_eq("t6 fill", 64'(fill_o), 64'd3);
        check_eq("t6 busy", 64'(busy_o), 64'd1);
        ac_ready_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("t6 reset");
        step();
        rst_ni = 1'b1;
        ac_ready_i = 1'b1;
        drive_push(64'h6000, 4'b1101, 3'b011);
        step();
        ac_valid_i = 1'b0;
        #1;
        check_eq("t6 new valid", 64'(ac_valid_o), 64'd1);
        check_eq("t6 new addr", ac_addr_o, 64'h6000);
        step();
        #1;
        check_eq("t6 new busy", 64'(busy_o), 64'd1);
        retire();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
